pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline: forwarding selects,
// load-use / branch stalls, taken-branch flush and multi-cycle EX freeze.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MC_LAT   = 4,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_branch,
    input  logic              id_multicycle,
    input  logic              branch_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic [1:0]        id_fwd_a,
    output logic [1:0]        id_fwd_b
);

    localparam int unsigned CW       = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic        MC_EN    = 1'(MC_LAT > 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [REG_AW-1:0] idex_rd_q, idex_rs1_q, idex_rs2_q;
    logic              idex_rw_q, idex_mr_q, idex_mc_q;
    logic [REG_AW-1:0] exmem_rd_q;
    logic              exmem_rw_q, exmem_mr_q;
    logic [REG_AW-1:0] memwb_rd_q;
    logic              memwb_rw_q;

    logic src1_v, src2_v, ex_hit, mem_hit;
    logic load_use, br_stall, stall, freeze, flush;

    function automatic logic hit(input logic [REG_AW-1:0] r,
                                 input logic [REG_AW-1:0] rd,
                                 input logic              we);
        return we && (rd == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    // EX/MEM is the younger producer, so it is checked first.
    function automatic logic [1:0] fsel(input logic              en,
                                        input logic [REG_AW-1:0] r,
                                        input logic [REG_AW-1:0] m_rd,
                                        input logic              m_rw,
                                        input logic [REG_AW-1:0] w_rd,
                                        input logic              w_rw);
        if (en && hit(r, m_rd, m_rw)) return 2'b00;
        if (en && hit(r, w_rd, w_rw)) return 2'b01;
        return 2'b10;
    endfunction

    assign src1_v = id_valid && id_use_rs1;
    assign src2_v = id_valid && id_use_rs2;

    assign ex_hit  = (src1_v && hit(id_rs1, idex_rd_q, idex_rw_q)) ||
                     (src2_v && hit(id_rs2, idex_rd_q, idex_rw_q));
    assign mem_hit = (src1_v && hit(id_rs1, exmem_rd_q, exmem_rw_q)) ||
                     (src2_v && hit(id_rs2, exmem_rd_q, exmem_rw_q));

    assign load_use = idex_mr_q && ex_hit;
    assign br_stall = id_branch && (ex_hit || (exmem_mr_q && mem_hit));
    assign stall    = load_use || br_stall;
    assign flush    = !rst && id_valid && id_branch && branch_taken;
    assign freeze   = ((state_q == RUN) && idex_mc_q && MC_EN) ||
                      ((state_q == MC_WAIT) && (cnt_q != '0));

    assign ex_fwd_a = fsel(1'b1, idex_rs1_q, exmem_rd_q, exmem_rw_q, memwb_rd_q, memwb_rw_q);
    assign ex_fwd_b = fsel(1'b1, idex_rs2_q, exmem_rd_q, exmem_rw_q, memwb_rd_q, memwb_rw_q);
    assign id_fwd_a = fsel(src1_v, id_rs1, exmem_rd_q, exmem_rw_q, memwb_rd_q, memwb_rw_q);
    assign id_fwd_b = fsel(src2_v, id_rs2, exmem_rd_q, exmem_rw_q, memwb_rd_q, memwb_rw_q);

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (freeze) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_bubble = 1'b1;
        end else if (stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (flush) begin
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (idex_mc_q && MC_EN) begin
                    state_d = MC_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            MC_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            idex_rd_q  <= '0;
            idex_rs1_q <= '0;
            idex_rs2_q <= '0;
            idex_rw_q  <= 1'b0;
            idex_mr_q  <= 1'b0;
            idex_mc_q  <= 1'b0;
            exmem_rd_q <= '0;
            exmem_rw_q <= 1'b0;
            exmem_mr_q <= 1'b0;
            memwb_rd_q <= '0;
            memwb_rw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idex_we) begin
                idex_rd_q  <= id_rd;
                idex_rs1_q <= id_rs1;
                idex_rs2_q <= id_rs2;
                idex_rw_q  <= id_regwrite   && id_valid && !idex_bubble;
                idex_mr_q  <= id_memread    && id_valid && !idex_bubble;
                idex_mc_q  <= id_multicycle && id_valid && !idex_bubble;
            end
            exmem_rd_q <= idex_rd_q;
            exmem_rw_q <= idex_rw_q && !exmem_bubble;
            exmem_mr_q <= idex_mr_q && !exmem_bubble;
            memwb_rd_q <= exmem_rd_q;
            memwb_rw_q <= exmem_rw_q;
        end
    end

endmodule
